// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register write-hazard scoreboard with a fixed-latency retirement pipeline
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int WB_LATENCY = 2,
    parameter int KILL_DEPTH = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      a_addr,
    input  logic [REG_ADDR_W-1:0]      b_addr,
    input  logic                       a_used,
    input  logic                       b_used,
    input  logic [REG_ADDR_W-1:0]      c_addr,
    input  logic                       reg_write,
    input  logic                       flush,
    input  logic                       clear_stats,
    output logic                       stall,
    output logic                       issue_fire,
    output logic [2**REG_ADDR_W-1:0]   pending,
    output logic                       retire_valid,
    output logic [REG_ADDR_W-1:0]      retire_addr,
    output logic [15:0]                stall_count
);

    localparam int NUM_REGS = 2**REG_ADDR_W;

    logic [WB_LATENCY-1:0] r_valid;
    logic [REG_ADDR_W-1:0] r_addr [WB_LATENCY];
    logic [NUM_REGS-1:0]   r_pending;
    logic [15:0]           r_stall_count;

    logic [WB_LATENCY-1:0] w_valid_nxt;
    logic [REG_ADDR_W-1:0] w_addr_nxt [WB_LATENCY];
    logic [NUM_REGS-1:0]   w_pending_nxt;
    logic                  w_hazard;
    logic                  w_load;

    assign w_hazard   = (a_used && r_pending[a_addr]) ||
                        (b_used && r_pending[b_addr]) ||
                        (reg_write && r_pending[c_addr]);
    assign stall      = issue_valid && w_hazard;
    assign issue_fire = issue_valid && !w_hazard && !RST && !flush;
    assign w_load     = issue_fire && reg_write && !((ZERO_REG != 0) && (c_addr == '0));

    // Invalid stages carry address 0 so retire_addr reads 0 whenever nothing retires.
    always_comb begin
        w_valid_nxt   = '0;
        w_pending_nxt = '0;
        for (int i = 0; i < WB_LATENCY; i++) begin
            w_addr_nxt[i] = '0;
        end
        w_valid_nxt[0] = w_load;
        w_addr_nxt[0]  = w_load ? c_addr : '0;
        for (int i = 1; i < WB_LATENCY; i++) begin
            w_valid_nxt[i] = r_valid[i-1];
            w_addr_nxt[i]  = r_addr[i-1];
        end
        // Kill applies to the post-shift youngest stages.
        for (int i = 0; i < KILL_DEPTH; i++) begin
            if (flush) begin
                w_valid_nxt[i] = 1'b0;
                w_addr_nxt[i]  = '0;
            end
        end
        for (int i = 0; i < WB_LATENCY; i++) begin
            if (w_valid_nxt[i]) begin
                w_pending_nxt[w_addr_nxt[i]] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            w_pending_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid       <= '0;
            r_pending     <= '0;
            r_stall_count <= '0;
            for (int i = 0; i < WB_LATENCY; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid   <= w_valid_nxt;
            r_addr    <= w_addr_nxt;
            r_pending <= w_pending_nxt;
            if (clear_stats) begin
                r_stall_count <= '0;
            end else if (stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign pending      = r_pending;
    assign retire_valid = r_valid[WB_LATENCY-1];
    assign retire_addr  = r_addr[WB_LATENCY-1];
    assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        issue_valid, a_used, b_used, reg_write, flush, clear_stats;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic        stall, issue_fire, retire_valid;
    logic [15:0] pending, stall_count;
    logic [3:0]  retire_addr;

    logic        z_issue_valid, z_a_used, z_b_used, z_reg_write, z_flush, z_clear_stats;
    logic [3:0]  z_a_addr, z_b_addr, z_c_addr;
    logic        z_stall, z_issue_fire, z_retire_valid;
    logic [15:0] z_pending, z_stall_count;
    logic [3:0]  z_retire_addr;

    hazard_scoreboard dut (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid),
        .a_addr(a_addr), .b_addr(b_addr), .a_used(a_used), .b_used(b_used),
        .c_addr(c_addr), .reg_write(reg_write), .flush(flush), .clear_stats(clear_stats),
        .stall(stall), .issue_fire(issue_fire), .pending(pending),
        .retire_valid(retire_valid), .retire_addr(retire_addr), .stall_count(stall_count)
    );

    hazard_scoreboard #(.REG_ADDR_W(4), .WB_LATENCY(8), .KILL_DEPTH(2), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .RST(RST), .issue_valid(z_issue_valid),
        .a_addr(z_a_addr), .b_addr(z_b_addr), .a_used(z_a_used), .b_used(z_b_used),
        .c_addr(z_c_addr), .reg_write(z_reg_write), .flush(z_flush), .clear_stats(z_clear_stats),
        .stall(z_stall), .issue_fire(z_issue_fire), .pending(z_pending),
        .retire_valid(z_retire_valid), .retire_addr(z_retire_addr), .stall_count(z_stall_count)
    );

    typedef struct {
        int         cyc;
        logic [3:0] addr;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Retirement monitor: pops expected retirements whenever the DUT presents one.
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL retire_missed: got none by cycle %0d, required addr %0d in cycle %0d",
                     cyc, q[0].addr, q[0].cyc);
            void'(q.pop_front());
        end
        if (retire_valid) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL retire_unexpected: got addr %0d in cycle %0d, required none",
                         retire_addr, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("retire_cycle", cyc, e.cyc);
                chk("retire_addr", {28'd0, retire_addr}, {28'd0, e.addr});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; a_used = 0; b_used = 0; reg_write = 0; flush = 0; clear_stats = 0;
        a_addr = 0; b_addr = 0; c_addr = 0;
    endtask

    task automatic z_idle();
        z_issue_valid = 0; z_a_used = 0; z_b_used = 0; z_reg_write = 0; z_flush = 0;
        z_clear_stats = 0; z_a_addr = 0; z_b_addr = 0; z_c_addr = 0;
    endtask

    task automatic wr(input logic [3:0] c);
        idle();
        issue_valid = 1; reg_write = 1; c_addr = c;
    endtask

    task automatic z_wr(input logic [3:0] c);
        z_idle();
        z_issue_valid = 1; z_reg_write = 1; z_c_addr = c;
    endtask

    task automatic push(input int c, input logic [3:0] a);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        q.push_back(e);
    endtask

    logic any_ret;

    initial begin
        idle();
        z_idle();
        RST = 1;
        tick();
        tick();
        wr(4'd9);
        #1 chk("fire_in_reset", issue_fire, 0);
        tick();
        RST = 0;
        idle();
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_retire_addr", retire_addr, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_stall", stall, 0);

        // Single write to r3
        wr(4'd3);
        #1 chk("w3_fire", issue_fire, 1);
        push(cyc + 2, 4'd3);
        tick(); idle();
        chk("w3_pending_c1", pending, 16'h0008);
        tick();
        chk("w3_pending_c2", pending, 16'h0008);
        tick();
        chk("w3_pending_c3", pending, 16'h0000);

        // RAW on source a
        wr(4'd5);
        push(cyc + 2, 4'd5);
        tick(); idle();
        issue_valid = 1; a_used = 1; a_addr = 4'd5;
        #1;
        chk("raw_stall_c1", stall, 1);
        chk("raw_fire_c1", issue_fire, 0);
        tick();
        chk("raw_stall_c2", stall, 1);
        tick();
        chk("raw_stall_c3", stall, 0);
        chk("raw_fire_c3", issue_fire, 1);
        chk("raw_stall_count", stall_count, 2);
        tick(); idle();

        // Source b, unused source, and WAW hazards against r10
        wr(4'd10);
        push(cyc + 2, 4'd10);
        tick(); idle();
        issue_valid = 1; a_used = 1; a_addr = 4'd1; b_addr = 4'd10;
        #1 chk("b_unused_stall", stall, 0);
        b_used = 1;
        #1 chk("b_used_stall", stall, 1);
        idle();
        issue_valid = 1; reg_write = 1; c_addr = 4'd10;
        #1 chk("waw_stall", stall, 1);
        tick(); idle();
        chk("waw_stall_count", stall_count, 3);
        clear_stats = 1;
        tick(); idle();
        chk("clear_stall_count", stall_count, 0);

        // Flush blocks a simultaneous issue, in-flight write still retires
        wr(4'd4);
        push(cyc + 2, 4'd4);
        tick();
        wr(4'd6);
        flush = 1;
        #1 chk("flush_fire", issue_fire, 0);
        tick(); idle();
        chk("flush_pending_c2", pending, 16'h0010);
        tick();
        chk("flush_pending_c3", pending, 16'h0000);

        // Flush with two writes already in flight: older stages continue
        wr(4'd4);
        push(cyc + 2, 4'd4);
        tick();
        wr(4'd11);
        #1 chk("w11_fire", issue_fire, 1);
        push(cyc + 2, 4'd11);
        tick(); idle();
        flush = 1;
        #1 chk("flush2_pending", pending, 16'h0810);
        tick(); idle();
        chk("flush2_pending_after", pending, 16'h0800);
        tick();
        chk("flush2_pending_end", pending, 16'h0000);

        // ZERO_REG=1 instance: r0 never pending and never hazards
        z_wr(4'd0);
        #1 chk("z0_fire", z_issue_fire, 1);
        tick(); z_idle();
        z_issue_valid = 1; z_a_used = 1; z_a_addr = 4'd0;
        #1;
        chk("z0_stall", z_stall, 0);
        chk("z0_read_fire", z_issue_fire, 1);
        chk("z0_pending", z_pending, 0);
        any_ret = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); z_idle();
            any_ret = any_ret | z_retire_valid;
        end
        chk("z0_no_retire", any_ret, 0);

        // KILL_DEPTH=2: flush one cycle after issue cancels that write
        z_wr(4'd1);
        tick();
        z_wr(4'd2);
        z_flush = 1;
        #1;
        chk("zk_fire", z_issue_fire, 0);
        chk("zk_pending", z_pending, 16'h0002);
        tick(); z_idle();
        chk("zk_killed", z_pending, 16'h0000);
        any_ret = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_ret = any_ret | z_retire_valid;
        end
        chk("zk_no_retire", any_ret, 0);

        // Saturation: 8 stalled cycles per 9-cycle round on the WB_LATENCY=8 instance
        z_wr(4'd7);
        tick();
        for (int r = 0; r < 8200; r++) begin
            z_idle();
            z_issue_valid = 1; z_a_used = 1; z_a_addr = 4'd7;
            repeat (8) tick();
            if (r == 0) chk("zs_count_round0", z_stall_count, 8);
            z_wr(4'd7);
            tick();
        end
        chk("zs_saturated", z_stall_count, 16'hFFFF);
        z_idle();
        z_issue_valid = 1; z_a_used = 1; z_a_addr = 4'd7; z_clear_stats = 1;
        #1 chk("zs_stall_during_clear", z_stall, 1);
        tick();
        z_clear_stats = 0;
        chk("zs_cleared", z_stall_count, 0);
        tick();
        chk("zs_count_after_clear", z_stall_count, 1);
        z_idle();
        repeat (10) tick();

        // Reset with two writes in flight
        wr(4'd7);
        push(cyc + 2, 4'd7);
        tick();
        wr(4'd8);
        #1 chk("w8_fire", issue_fire, 1);
        push(cyc + 2, 4'd8);
        tick();
        wr(4'd9);
        RST = 1;
        while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
        #1;
        chk("rst2_fire", issue_fire, 0);
        chk("rst2_pending_before", pending, 16'h0180);
        tick();
        RST = 0;
        idle();
        chk("rst2_pending", pending, 0);
        chk("rst2_retire_valid", retire_valid, 0);
        repeat (5) tick();

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_ADDR_W, default 4: register address width; NUM_REGS = 2**REG_ADDR_W.
REQ-002 Parameter WB_LATENCY, default 2, legal 1..8: cycles from issue to retirement of a register write.
REQ-003 Parameter KILL_DEPTH, default 1, legal 0..WB_LATENCY: youngest in-flight stages cancelled by flush.
REQ-004 Parameter ZERO_REG, default 0: 1 means register 0 is never pending and never hazards.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 CLK  in  1  sole clock; all state updates on rising edge.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 issue_valid  in  1  decoded instruction presented for issue.
REQ-009 a_addr, b_addr  in  REG_ADDR_W  source register addresses.
REQ-010 a_used, b_used  in  1  source actually read.
REQ-011 c_addr  in  REG_ADDR_W  destination register address.
REQ-012 reg_write  in  1  instruction writes c_addr.
REQ-013 flush  in  1  taken jump; cancels younger in-flight writes.
REQ-014 clear_stats  in  1  clears stall_count.
REQ-015 stall  out  1  combinational hazard indication.
REQ-016 issue_fire  out  1  combinational; instruction accepted this cycle.
REQ-017 pending  out  NUM_REGS  registered per-register in-flight-write mask.
REQ-018 retire_valid  out  1  registered; a write retires this cycle.
REQ-019 retire_addr  out  REG_ADDR_W  registered; address of retiring write.
REQ-020 stall_count  out  16  registered saturating count of stalled cycles.

Function
REQ-021 Tracking SHALL be a WB_LATENCY-deep shift pipeline of {valid, addr} stages s0..s(WB_LATENCY-1), advancing every cycle.
REQ-022 pending[r] SHALL be 1 when any valid stage holds addr r; forced 0 for r=0 when ZERO_REG=1.
REQ-023 stall SHALL be issue_valid AND (a_used AND pending[a_addr] OR b_used AND pending[b_addr] OR reg_write AND pending[c_addr]).
REQ-024 issue_fire SHALL be issue_valid AND NOT stall AND NOT RST AND NOT flush.
REQ-025 On issue_fire with reg_write=1, s0 SHALL load {1, c_addr} at the next edge; otherwise s0 loads valid=0.
REQ-026 With ZERO_REG=1, reg_write to address 0 SHALL load s0 valid=0.
REQ-027 retire_valid/retire_addr SHALL reflect stage s(WB_LATENCY-1): first asserted WB_LATENCY cycles after the fire edge, high exactly one cycle.
REQ-028 On flush, stages s0..s(KILL_DEPTH-1) SHALL be invalidated at the same edge as the shift; older stages continue and retire normally.
REQ-029 flush SHALL take priority over a simultaneous issue: the presented instruction is not entered and issue_fire=0.
REQ-030 Same-address writes in multiple stages SHALL be legal; pending stays set until the last one retires.
REQ-031 stall_count SHALL increment by 1 each cycle stall=1, saturate at 16'hFFFF, and clear_stats SHALL zero it with priority over increment.
REQ-032 A stalled instruction SHALL not alter any state other than stall_count.

Reset
REQ-033 While RST=1 at an edge: all stages invalid, pending=0, retire_valid=0, retire_addr=0, stall_count=0.
REQ-034 RST mid-operation SHALL discard all in-flight writes with no retirement pulses afterward; issue_fire=0 during RST.

Verification (WB_LATENCY=2, KILL_DEPTH=1, ZERO_REG=0 unless stated)
REQ-035 Reset then fire write c=3 at cycle 0 -> pending[3]=1 cycles 1-2, retire_valid=1 with retire_addr=3 in cycle 2, pending=0 from cycle 3.
REQ-036 Cycle 1 after write c=5, present a_used=1, a_addr=5 -> stall=1 cycles 1-2, issue_fire=1 in cycle 3, stall_count=2.
REQ-037 Fire c=4 at cycle 0, c=6 at cycle 1, flush in cycle 1 -> 6 never enters, 4 retires cycle 2, pending=0 at cycle 3.
REQ-038 ZERO_REG=1, write c=0 then read a_addr=0 next cycle -> no stall, no retire_valid pulse.
REQ-039 Hold a hazard 70000 cycles -> stall_count saturates at 16'hFFFF; clear_stats pulse -> 0 next cycle.
REQ-040 Assert RST with two writes in flight -> pending=0 next cycle and no retire_valid pulses follow.
